// File: rtl/io_port_pkg.sv
// Shared register map, STATUS bit positions and sizing helper for io_port.
package io_port_pkg;

  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_SW     = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_LED    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_BLINK  = 2'd3;

  localparam int unsigned CHG_BIT    = 0;
  localparam int unsigned IRQ_EN_BIT = 1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One switch bit: 2-flop synchroniser followed by a consecutive-difference debouncer.
module io_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic stable_o,
  output logic accept_c_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive differing samples; accept on the last one, otherwise restart.
  always_comb begin
    cnt_d      = '0;
    stable_d   = stable_q;
    accept_c_o = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d   = sync2_q;
        accept_c_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser and debounce state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= pin_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/io_port.sv
// Memory-mapped switch/LED peripheral: debounced switches, blinking LEDs, sticky change flag.
module io_port
  import io_port_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLINK_DIV       = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  irq,
  input  logic [WIDTH-1:0]      switches,
  output logic [WIDTH-1:0]      LEDs
);

  localparam int unsigned BLK_W = cnt_width(BLINK_DIV);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [WIDTH-1:0]      sw_q;
  logic [WIDTH-1:0]      sw_accept_c;
  logic [WIDTH-1:0]      led_q, led_d;
  logic [WIDTH-1:0]      blink_q, blink_d;
  logic                  chg_q, chg_d;
  logic                  irq_en_q, irq_en_d;
  logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic                  phase_q, phase_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q;
  logic [1:0]            status_c;
  logic                  unused_c;

  // Write data bits above the register widths are intentionally ignored.
  assign unused_c = ^wdata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock     (clock),
      .reset     (reset),
      .pin_i     (switches[g]),
      .stable_o  (sw_q[g]),
      .accept_c_o(sw_accept_c[g])
    );
  end

  // STATUS as seen by reads.
  always_comb begin
    status_c             = '0;
    status_c[CHG_BIT]    = chg_q;
    status_c[IRQ_EN_BIT] = irq_en_q;
  end

  // Register writes; a switch acceptance overrides a same-cycle CHG clear.
  always_comb begin
    led_d    = led_q;
    blink_d  = blink_q;
    irq_en_d = irq_en_q;
    chg_d    = chg_q;
    if (wr_en) begin
      case (addr)
        ADDR_LED:    led_d = wdata[WIDTH-1:0];
        ADDR_STATUS: begin
          irq_en_d = wdata[IRQ_EN_BIT];
          if (wdata[CHG_BIT]) chg_d = 1'b0;
        end
        ADDR_BLINK:  blink_d = wdata[WIDTH-1:0];
        default:     ;
      endcase
    end
    if (|sw_accept_c) chg_d = 1'b1;
  end

  // Read mux samples pre-write register values.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        ADDR_SW:     rdata_d = DATA_WIDTH'(sw_q);
        ADDR_LED:    rdata_d = DATA_WIDTH'(led_q);
        ADDR_STATUS: rdata_d = DATA_WIDTH'(status_c);
        default:     rdata_d = DATA_WIDTH'(blink_q);
      endcase
    end
  end

  // Blink divider: phase toggles on each wrap of the 0..BLINK_DIV-1 counter.
  always_comb begin
    blk_cnt_d = blk_cnt_q + BLK_W'(1);
    phase_d   = phase_q;
    if (blk_cnt_q == BLK_LAST) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end
  end

  // Register state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q     <= '0;
      blink_q   <= '0;
      chg_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      led_q     <= led_d;
      blink_q   <= blink_d;
      chg_q     <= chg_d;
      irq_en_q  <= irq_en_d;
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rd_en;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign irq         = chg_q & irq_en_q;
  assign LEDs        = led_q & (~blink_q | {WIDTH{phase_q}});

endmodule
